// File: rtl/data_mem_pkg.sv
`default_nettype none
// ============================================================================
// Module  : data_mem_pkg
// Brief   : Shared size codes, FSM states and helpers for data_mem_hs.
// Revision: 1.0
// ============================================================================
package data_mem_pkg;

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;
  localparam logic [1:0] SZ_D = 2'd3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  function automatic logic [3:0] size_bytes(input logic [1:0] size);
    return 4'd1 << size;
  endfunction

endpackage
`default_nettype wire

// File: rtl/data_mem_hs_fmt.sv
`default_nettype none
// ============================================================================
// Module  : mem_lane_fmt
// Brief   : Byte enables, store lane masking, load extension and access checks.
// Revision: 1.0
// ============================================================================
module mem_lane_fmt
  import data_mem_pkg::*;
#(
  parameter int DATA_W = 64,
  parameter int DEPTH  = 8192,
  parameter int ADDR_W = 64
) (
  input  logic [1:0]        i_size,
  input  logic              i_unsigned,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic [DATA_W-1:0] i_raw,
  output logic [7:0]        o_be,
  output logic [DATA_W-1:0] o_wdata,
  output logic [DATA_W-1:0] o_rdata,
  output logic              o_err
);

  localparam logic [ADDR_W-1:0] c_DEPTH = ADDR_W'(DEPTH);

  logic [ADDR_W-1:0] w_n;
  logic              w_misalign;
  logic              w_range;
  logic              w_err;
  logic              w_sx;

  assign w_n        = ADDR_W'(size_bytes(i_size));
  assign w_misalign = |(i_addr & (w_n - 1'b1));
  // Full-width compare so huge addresses never alias into the array.
  assign w_range    = i_addr > (c_DEPTH - w_n);
  assign w_err      = w_misalign | w_range;
  assign o_err      = w_err;
  assign w_sx       = ~i_unsigned;

  always_comb begin
    o_be = 8'h00;
    case (i_size)
      SZ_B:    o_be = 8'h01;
      SZ_H:    o_be = 8'h03;
      SZ_W:    o_be = 8'h0F;
      default: o_be = 8'hFF;
    endcase
  end

  always_comb begin
    o_wdata = '0;
    for (int i = 0; i < 8; i++) begin
      o_wdata[8*i +: 8] = o_be[i] ? i_wdata[8*i +: 8] : 8'h00;
    end
  end

  always_comb begin
    o_rdata = '0;
    if (!w_err) begin
      case (i_size)
        SZ_B:    o_rdata = {{56{w_sx & i_raw[7]}},  i_raw[7:0]};
        SZ_H:    o_rdata = {{48{w_sx & i_raw[15]}}, i_raw[15:0]};
        SZ_W:    o_rdata = {{32{w_sx & i_raw[31]}}, i_raw[31:0]};
        default: o_rdata = i_raw;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/data_mem_hs.sv
`default_nettype none
// ============================================================================
// Module  : data_mem_hs
// Brief   : Byte-addressable data memory with valid/ready handshake and latency.
// Revision: 1.0
// ============================================================================
module data_mem_hs
  import data_mem_pkg::*;
#(
  parameter int DATA_W = 64,
  parameter int DEPTH  = 8192,
  parameter int ADDR_W = 64,
  parameter int LAT    = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_err
);

  localparam int AW    = $clog2(DEPTH);
  localparam int CNT_W = (LAT > 1) ? $clog2(LAT) : 1;

  state_t             r_state;
  state_t             w_next;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_we;
  logic [1:0]         r_size;
  logic               r_uns;
  logic [ADDR_W-1:0]  r_addr;
  logic [DATA_W-1:0]  r_wdata;
  logic               r_resp_valid;
  logic [DATA_W-1:0]  r_resp_rdata;
  logic               r_resp_err;
  logic [7:0]         r_mem [DEPTH];

  logic               w_accept;
  logic               w_access;
  logic               w_store;
  logic [AW-1:0]      w_base;
  logic [DATA_W-1:0]  w_raw;
  logic [7:0]         w_be;
  logic [DATA_W-1:0]  w_wlane;
  logic [DATA_W-1:0]  w_rdata;
  logic               w_err;

  assign w_accept   = req_valid && (r_state == IDLE);
  assign w_access   = (r_state == WAIT) && (r_cnt == '0);
  // Gated by rst so a store reaching its access edge during reset is dropped.
  assign w_store    = w_access && r_we && !w_err && rst;
  assign w_base     = r_addr[AW-1:0];
  assign resp_valid = r_resp_valid;
  assign resp_rdata = r_resp_rdata;
  assign resp_err   = r_resp_err;

  always_comb begin
    w_raw = '0;
    for (int i = 0; i < 8; i++) begin
      w_raw[8*i +: 8] = r_mem[w_base + AW'(i)];
    end
  end

  mem_lane_fmt #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_fmt (
    .i_size     (r_size),
    .i_unsigned (r_uns),
    .i_addr     (r_addr),
    .i_wdata    (r_wdata),
    .i_raw      (w_raw),
    .o_be       (w_be),
    .o_wdata    (w_wlane),
    .o_rdata    (w_rdata),
    .o_err      (w_err)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next    = r_state;
    req_ready = 1'b0;
    case (r_state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) w_next = WAIT;
      end
      WAIT: begin
        if (r_cnt == '0) w_next = RESP;
      end
      RESP: begin
        if (resp_ready) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_we    <= req_we;
      r_size  <= req_size;
      r_uns   <= req_unsigned;
      r_addr  <= req_addr;
      r_wdata <= req_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_cnt        <= '0;
      r_resp_valid <= 1'b0;
      r_resp_rdata <= '0;
      r_resp_err   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (req_valid) r_cnt <= CNT_W'(LAT - 1);
        end
        WAIT: begin
          if (r_cnt != '0) begin
            r_cnt <= r_cnt - 1'b1;
          end else begin
            r_resp_valid <= 1'b1;
            r_resp_rdata <= r_we ? '0 : w_rdata;
            r_resp_err   <= w_err;
          end
        end
        RESP: begin
          if (resp_ready) begin
            r_resp_valid <= 1'b0;
            r_resp_rdata <= '0;
            r_resp_err   <= 1'b0;
          end
        end
        default: r_cnt <= '0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < 8; i++) begin
      if (w_store && w_be[i]) begin
        r_mem[w_base + AW'(i)] <= w_wlane[8*i +: 8];
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_data_mem_hs.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module  : tb_data_mem_hs
// Brief   : Directed self-checking bench for data_mem_hs.
// Revision: 1.0
// ============================================================================
module tb_data_mem_hs;

  localparam int DEPTH = 8192;
  localparam int LAT   = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [1:0]  req_size = 2'd0;
  logic        req_unsigned = 1'b0;
  logic [63:0] req_addr = '0;
  logic [63:0] req_wdata = '0;
  logic        resp_valid;
  logic        resp_ready = 1'b0;
  logic [63:0] resp_rdata;
  logic        resp_err;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  data_mem_hs #(
    .DATA_W (64),
    .DEPTH  (DEPTH),
    .ADDR_W (64),
    .LAT    (LAT)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_we       (req_we),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .resp_valid   (resp_valid),
    .resp_ready   (resp_ready),
    .resp_rdata   (resp_rdata),
    .resp_err     (resp_err)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=0x%h expected=0x%h", tag, obs, exp);
    end
  endtask

  task automatic drive_req(input logic we, input logic [1:0] size, input logic uns,
                           input logic [63:0] addr, input logic [63:0] wdata);
    req_we       = we;
    req_size     = size;
    req_unsigned = uns;
    req_addr     = addr;
    req_wdata    = wdata;
    req_valid    = 1'b1;
  endtask

  // Scrambles request inputs after the accept edge; the DUT must ignore them.
  task automatic scramble_req();
    req_valid = 1'b0;
    req_we    = ~req_we;
    req_addr  = 64'h0000_0000_0000_0008;
    req_wdata = '1;
  endtask

  task automatic wait_resp(input string tag, output int lat);
    bit got = 0;
    lat = 0;
    while (!got && lat < 20) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      if (resp_valid) got = 1;
    end
    chk({tag, "_resp_seen"}, 64'(got), 64'd1);
  endtask

  task automatic access(input string tag, input logic we, input logic [1:0] size,
                        input logic uns, input logic [63:0] addr, input logic [63:0] wdata,
                        output logic [63:0] rd, output logic err);
    int lat;
    @(negedge clk);
    chk({tag, "_req_ready"}, 64'(req_ready), 64'd1);
    drive_req(we, size, uns, addr, wdata);
    @(posedge clk);
    #1 scramble_req();
    wait_resp(tag, lat);
    chk({tag, "_latency"}, 64'(lat), 64'(LAT));
    rd = resp_rdata;
    err = resp_err;
    resp_ready = 1'b1;
    @(posedge clk);
    #1 resp_ready = 1'b0;
  endtask

  task automatic ld(input string tag, input logic [1:0] size, input logic uns,
                    input logic [63:0] addr, input logic [63:0] exp_rd, input logic exp_err);
    logic [63:0] rd;
    logic        err;
    access(tag, 1'b0, size, uns, addr, 64'hDEAD_DEAD_DEAD_DEAD, rd, err);
    chk({tag, "_rdata"}, rd, exp_rd);
    chk({tag, "_err"}, 64'(err), 64'(exp_err));
  endtask

  task automatic st(input string tag, input logic [1:0] size, input logic [63:0] addr,
                    input logic [63:0] wdata, input logic exp_err);
    logic [63:0] rd;
    logic        err;
    access(tag, 1'b1, size, 1'b0, addr, wdata, rd, err);
    chk({tag, "_rdata"}, rd, 64'd0);
    chk({tag, "_err"}, 64'(err), 64'(exp_err));
  endtask

  initial begin
    int lat;

    rst = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_req_ready", 64'(req_ready), 64'd1);
    chk("rst_resp_valid", 64'(resp_valid), 64'd0);
    chk("rst_resp_rdata", resp_rdata, 64'd0);
    chk("rst_resp_err", 64'(resp_err), 64'd0);
    rst = 1'b1;

    st("st_d10", 2'd3, 64'h10, 64'h0C3C_3EAA_F00F_CC33, 1'b0);
    ld("ld_d10", 2'd3, 1'b0, 64'h10, 64'h0C3C_3EAA_F00F_CC33, 1'b0);
    ld("ld_b10", 2'd0, 1'b0, 64'h10, 64'h0000_0000_0000_0033, 1'b0);
    ld("ld_h14s", 2'd1, 1'b0, 64'h14, 64'h0000_0000_0000_3EAA, 1'b0);
    ld("ld_h12s", 2'd1, 1'b0, 64'h12, 64'hFFFF_FFFF_FFFF_F00F, 1'b0);
    ld("ld_h12u", 2'd1, 1'b1, 64'h12, 64'h0000_0000_0000_F00F, 1'b0);
    ld("ld_w10s", 2'd2, 1'b0, 64'h10, 64'hFFFF_FFFF_F00F_CC33, 1'b0);
    ld("ld_w10u", 2'd2, 1'b1, 64'h10, 64'h0000_0000_F00F_CC33, 1'b0);
    ld("ld_d10u", 2'd3, 1'b1, 64'h10, 64'h0C3C_3EAA_F00F_CC33, 1'b0);

    st("st_d20", 2'd3, 64'h20, 64'h1122_3344_5566_7788, 1'b0);
    st("st_b20", 2'd0, 64'h20, 64'hDEAD_BEEF_CAFE_BA80, 1'b0);
    ld("ld_b20s", 2'd0, 1'b0, 64'h20, 64'hFFFF_FFFF_FFFF_FF80, 1'b0);
    ld("ld_b20u", 2'd0, 1'b1, 64'h20, 64'h0000_0000_0000_0080, 1'b0);
    ld("ld_d20", 2'd3, 1'b0, 64'h20, 64'h1122_3344_5566_7780, 1'b0);
    st("st_h26", 2'd1, 64'h26, 64'hFFFF_FFFF_FFFF_ABCD, 1'b0);
    ld("ld_d20_h", 2'd3, 1'b0, 64'h20, 64'hABCD_3344_5566_7780, 1'b0);

    st("st_w22_mis", 2'd2, 64'h22, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1);
    ld("ld_d20_after", 2'd3, 1'b0, 64'h20, 64'hABCD_3344_5566_7780, 1'b0);
    ld("ld_h11_mis", 2'd1, 1'b0, 64'h11, 64'd0, 1'b1);
    ld("ld_d_top4", 2'd3, 1'b0, 64'(DEPTH - 4), 64'd0, 1'b1);
    st("st_w_top4", 2'd2, 64'(DEPTH - 4), 64'h0000_0000_89AB_CDEF, 1'b0);
    ld("ld_w_top4u", 2'd2, 1'b1, 64'(DEPTH - 4), 64'h0000_0000_89AB_CDEF, 1'b0);
    ld("ld_w_top4s", 2'd2, 1'b0, 64'(DEPTH - 4), 64'hFFFF_FFFF_89AB_CDEF, 1'b0);
    ld("ld_b_depth", 2'd0, 1'b0, 64'(DEPTH), 64'd0, 1'b1);
    ld("ld_b_huge", 2'd0, 1'b1, 64'h8000_0000_0000_0010, 64'd0, 1'b1);
    st("st_d_huge", 2'd3, 64'h8000_0000_0000_0010, 64'h5555_5555_5555_5555, 1'b1);
    ld("ld_d10_alias", 2'd3, 1'b0, 64'h10, 64'h0C3C_3EAA_F00F_CC33, 1'b0);

    // Response held off by the consumer.
    @(negedge clk);
    drive_req(1'b0, 2'd3, 1'b0, 64'h10, 64'h0);
    @(posedge clk);
    #1 scramble_req();
    wait_resp("hold", lat);
    for (int k = 0; k < 5; k++) begin
      @(posedge clk);
      @(negedge clk);
      chk("hold_valid", 64'(resp_valid), 64'd1);
      chk("hold_rdata", resp_rdata, 64'h0C3C_3EAA_F00F_CC33);
      chk("hold_err", 64'(resp_err), 64'd0);
      chk("hold_req_ready", 64'(req_ready), 64'd0);
    end
    resp_ready = 1'b1;
    @(posedge clk);
    #1 resp_ready = 1'b0;
    @(negedge clk);
    chk("release_valid", 64'(resp_valid), 64'd0);
    chk("release_rdata", resp_rdata, 64'd0);
    chk("release_req_ready", 64'(req_ready), 64'd1);
    ld("after_release", 2'd0, 1'b1, 64'h17, 64'h0000_0000_0000_000C, 1'b0);

    // Reset lands on the store's access edge; the store must be dropped.
    st("st_d40", 2'd3, 64'h40, 64'h0102_0304_0506_0708, 1'b0);
    @(negedge clk);
    drive_req(1'b1, 2'd3, 1'b0, 64'h40, 64'hA5A5_A5A5_A5A5_A5A5);
    @(posedge clk);
    #1 scramble_req();
    @(posedge clk);
    @(negedge clk);
    chk("wait_req_ready", 64'(req_ready), 64'd0);
    rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("midrst_resp_valid", 64'(resp_valid), 64'd0);
    chk("midrst_req_ready", 64'(req_ready), 64'd1);
    rst = 1'b1;
    ld("ld_d40", 2'd3, 1'b0, 64'h40, 64'h0102_0304_0506_0708, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
